// File: rtl/mdc_pkg.sv
// mdc_pkg: shared types and defaults for the mdc_sched GCD scheduler.
package mdc_pkg;

   localparam int MDC_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mdc_engine.sv
// mdc_engine: subtractive GCD datapath. Loads an operand pair, then subtracts the
// smaller from the larger once per run cycle until one register reaches zero.
module mdc_engine
   import mdc_pkg::*;
#(
   parameter int W = MDC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         run,
   input  logic [W-1:0] a_ld,
   input  logic [W-1:0] b_ld,
   output logic         done,
   output logic [W-1:0] sum
);

   logic [W-1:0] a_r;
   logic [W-1:0] b_r;

   // Operand registers: load, one subtraction per run cycle, or hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r <= '0;
         b_r <= '0;
      end else if (ld) begin
         a_r <= a_ld;
         b_r <= b_ld;
      end else if (run && !done) begin
         if (b_r <= a_r) begin
            a_r <= a_r - b_r;
         end else begin
            b_r <= b_r - a_r;
         end
      end else begin
         a_r <= a_r;
         b_r <= b_r;
      end
   end

   // One operand is zero at termination, so the sum is the GCD.
   assign done = (a_r == '0) || (b_r == '0);
   assign sum  = a_r + b_r;

endmodule

// File: rtl/mdc_sched.sv
// mdc_sched: round-robin scheduler sharing one subtractive GCD engine among N_REQ requesters.
// Build option: define MDC_TIMEOUT_EN to add the MAX_ITER run-cycle timeout and res_err reporting.
module mdc_sched
   import mdc_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int W        = MDC_W,
   parameter int MAX_ITER = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*W-1:0]       a_in,
   input  logic [N_REQ*W-1:0]       b_in,
   output logic [N_REQ-1:0]         ack,
   output logic                     busy,
   output logic                     res_valid,
   output logic [$clog2(N_REQ)-1:0] res_id,
   output logic [W-1:0]             res,
   output logic                     res_err
);

   localparam int IDW = $clog2(N_REQ);

   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_LOAD = S_LOAD;
   localparam logic [1:0] ST_RUN  = S_RUN;
   localparam logic [1:0] ST_DONE = S_DONE;

   if (N_REQ < 2 || MAX_ITER < 1) begin : g_bad_params
      $error("mdc_sched: N_REQ must be >= 2 and MAX_ITER >= 1");
   end

   logic [1:0]     state_r;
   logic [1:0]     state_nxt_s;
   logic [IDW-1:0] ptr_r;
   logic [IDW-1:0] grant_r;
   logic [IDW-1:0] grant_s;
   logic [IDW-1:0] off_s;
   logic           any_req_s;
   logic           timeout_s;
   logic           eng_ld_s;
   logic           eng_run_s;
   logic           eng_done_s;
   logic [W-1:0]   eng_sum_s;
   logic [W-1:0]   ld_a_s;
   logic [W-1:0]   ld_b_s;

   // Round-robin search: lowest rotated offset from ptr_r whose request is set.
   always_comb begin
      any_req_s = |req;
      off_s     = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         if (req[(int'(ptr_r) + off) % N_REQ]) begin
            off_s = IDW'(off);
         end else begin
            off_s = off_s;
         end
      end
      grant_s = IDW'((int'(ptr_r) + int'(off_s)) % N_REQ);
   end

   // Next-state decode for the IDLE -> LOAD -> RUN -> DONE sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: state_nxt_s = ST_RUN;
         ST_RUN: begin
            if (eng_done_s || timeout_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM, arbiter pointer, grant latch and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         ptr_r     <= '0;
         grant_r   <= '0;
         ack       <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res       <= '0;
         res_err   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         busy      <= (state_nxt_s != ST_IDLE);
         ack       <= '0;
         res_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  grant_r <= grant_s;
                  ack     <= N_REQ'(1'b1) << grant_s;
               end else begin
                  grant_r <= grant_r;
               end
            end
            ST_LOAD: begin
               ptr_r <= (grant_r == IDW'(N_REQ - 1)) ? '0 : grant_r + 1'b1;
            end
            ST_RUN: begin
               if (eng_done_s) begin
                  res       <= eng_sum_s;
                  res_err   <= 1'b0;
                  res_id    <= grant_r;
                  res_valid <= 1'b1;
               end else if (timeout_s) begin
                  res       <= '0;
                  res_err   <= 1'b1;
                  res_id    <= grant_r;
                  res_valid <= 1'b1;
               end else begin
                  res <= res;
               end
            end
            ST_DONE: ptr_r <= ptr_r;
            default: ptr_r <= ptr_r;
         endcase
      end
   end

`ifdef MDC_TIMEOUT_EN
   localparam int CW = $clog2(MAX_ITER + 1);
   logic [CW-1:0] iter_r;

   // RUN-cycle counter, restarted for every job in LOAD.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iter_r <= '0;
      end else if (state_r == ST_LOAD) begin
         iter_r <= '0;
      end else if (state_r == ST_RUN && !timeout_s) begin
         iter_r <= iter_r + 1'b1;
      end else begin
         iter_r <= iter_r;
      end
   end

   // Natural termination has priority when both happen in the same cycle.
   assign timeout_s = (iter_r == CW'(MAX_ITER));
`else
   assign timeout_s = 1'b0;
`endif

   assign eng_ld_s  = (state_r == ST_LOAD);
   assign eng_run_s = (state_r == ST_RUN);
   assign ld_a_s    = a_in[int'(grant_r) * W +: W];
   assign ld_b_s    = b_in[int'(grant_r) * W +: W];

   mdc_engine #(
      .W (W)
   ) u_engine (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (eng_ld_s),
      .run   (eng_run_s),
      .a_ld  (ld_a_s),
      .b_ld  (ld_b_s),
      .done  (eng_done_s),
      .sum   (eng_sum_s)
   );

endmodule
